// File: rtl/amo_sequencer_if.sv
// Single-port data memory beat interface between the AMO sequencer (master)
// and the memory access unit (slave).
interface amo_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_err;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata, mem_err
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata, mem_err
  );
endinterface

// File: rtl/amo_sequencer.sv
// Multi-cycle sequencer for LR.W / SC.W / AMO read-modify-write ops over a
// single-port memory, owning the LR/SC reservation register.
module amo_sequencer #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned RSV_GRAN = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4:0]           amo_op,
  input  logic [XLEN-1:0]      addr,
  input  logic [XLEN-1:0]      rs2_data,
  output logic                 busy,
  amo_sequencer_if.master      mem,
  input  logic                 snoop_valid,
  input  logic [XLEN-1:0]      snoop_addr,
  input  logic                 rsv_clear,
  output logic                 done,
  output logic [XLEN-1:0]      result,
  output logic                 exc_valid,
  output logic [5:0]           exc_cause
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRead  = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [4:0] OpAdd  = 5'b00000;
  localparam logic [4:0] OpSwap = 5'b00001;
  localparam logic [4:0] OpLr   = 5'b00010;
  localparam logic [4:0] OpSc   = 5'b00011;
  localparam logic [4:0] OpXor  = 5'b00100;
  localparam logic [4:0] OpOr   = 5'b01000;
  localparam logic [4:0] OpAnd  = 5'b01100;
  localparam logic [4:0] OpMin  = 5'b10000;
  localparam logic [4:0] OpMax  = 5'b10100;
  localparam logic [4:0] OpMinu = 5'b11000;
  localparam logic [4:0] OpMaxu = 5'b11100;

  localparam logic [5:0] ExIllegalInstr     = 6'd2;
  localparam logic [5:0] ExLoadMisaligned   = 6'd4;
  localparam logic [5:0] ExLoadAccessFault  = 6'd5;
  localparam logic [5:0] ExStoreMisaligned  = 6'd6;
  localparam logic [5:0] ExStoreAccessFault = 6'd7;

  function automatic logic op_legal(input logic [4:0] op);
    case (op)
      OpAdd, OpSwap, OpLr, OpSc, OpXor, OpOr, OpAnd,
      OpMin, OpMax, OpMinu, OpMaxu: op_legal = 1'b1;
      default:                      op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] amo_alu(input logic [4:0]      op,
                                              input logic [XLEN-1:0] old,
                                              input logic [XLEN-1:0] rs2);
    case (op)
      OpSwap:  amo_alu = rs2;
      OpAdd:   amo_alu = old + rs2;
      OpXor:   amo_alu = old ^ rs2;
      OpOr:    amo_alu = old | rs2;
      OpAnd:   amo_alu = old & rs2;
      OpMin:   amo_alu = ($signed(old) < $signed(rs2)) ? old : rs2;
      OpMax:   amo_alu = ($signed(old) > $signed(rs2)) ? old : rs2;
      OpMinu:  amo_alu = (old < rs2) ? old : rs2;
      OpMaxu:  amo_alu = (old > rs2) ? old : rs2;
      default: amo_alu = old;
    endcase
  endfunction

  logic [1:0]      state_q, state_d;
  logic [4:0]      op_q, op_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] old_q, old_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            exc_q, exc_d;
  logic [5:0]      cause_q, cause_d;
  logic            rsv_valid_q, rsv_valid_d;
  logic [XLEN-1:0] rsv_addr_q, rsv_addr_d;
  logic            rsv_set, sc_clr, rsv_kill;
  logic [XLEN-1:0] rsv_cmp_addr;
  logic            sc_match;

  // Granule comparisons use shifts so the whole address stays referenced.
  assign sc_match = rsv_valid_q && ((addr >> RSV_GRAN) == (rsv_addr_q >> RSV_GRAN));

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rs2_d    = rs2_q;
    addr_d   = addr_q;
    old_d    = old_q;
    wdata_d  = wdata_q;
    result_d = result_q;
    exc_d    = exc_q;
    cause_d  = cause_q;
    rsv_set  = 1'b0;
    sc_clr   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          op_d     = amo_op;
          rs2_d    = rs2_data;
          addr_d   = addr;
          exc_d    = 1'b0;
          cause_d  = 6'd0;
          result_d = '0;
          if (addr[1:0] != 2'b00) begin
            exc_d   = 1'b1;
            cause_d = (amo_op == OpLr) ? ExLoadMisaligned : ExStoreMisaligned;
            state_d = StDone;
          end else if (!op_legal(amo_op)) begin
            exc_d   = 1'b1;
            cause_d = ExIllegalInstr;
            state_d = StDone;
          end else if (amo_op == OpSc) begin
            sc_clr = 1'b1;
            if (sc_match) begin
              wdata_d = rs2_data;
              state_d = StWrite;
            end else begin
              result_d = {{(XLEN-1){1'b0}}, 1'b1};
              state_d  = StDone;
            end
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead: begin
        if (mem.mem_ack) begin
          if (mem.mem_err) begin
            exc_d   = 1'b1;
            cause_d = (op_q == OpLr) ? ExLoadAccessFault : ExStoreAccessFault;
            state_d = StDone;
          end else begin
            old_d = mem.mem_rdata;
            if (op_q == OpLr) begin
              result_d = mem.mem_rdata;
              rsv_set  = 1'b1;
              state_d  = StDone;
            end else begin
              wdata_d = amo_alu(op_q, mem.mem_rdata, rs2_q);
              state_d = StWrite;
            end
          end
        end
      end
      StWrite: begin
        if (mem.mem_ack) begin
          if (mem.mem_err) begin
            exc_d   = 1'b1;
            cause_d = ExStoreAccessFault;
          end else begin
            result_d = (op_q == OpSc) ? '0 : old_q;
          end
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // A clear coincident with an LR set is checked against the address being set, and wins.
  always_comb begin
    rsv_cmp_addr = rsv_set ? addr_q : rsv_addr_q;
    rsv_kill     = rsv_clear || sc_clr ||
                   (snoop_valid && ((snoop_addr >> RSV_GRAN) == (rsv_cmp_addr >> RSV_GRAN)));
    rsv_addr_d   = rsv_set ? addr_q : rsv_addr_q;
    if (rsv_kill) begin
      rsv_valid_d = 1'b0;
    end else if (rsv_set) begin
      rsv_valid_d = 1'b1;
    end else begin
      rsv_valid_d = rsv_valid_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= 5'd0;
      rs2_q       <= '0;
      addr_q      <= '0;
      old_q       <= '0;
      wdata_q     <= '0;
      result_q    <= '0;
      exc_q       <= 1'b0;
      cause_q     <= 6'd0;
      rsv_valid_q <= 1'b0;
      rsv_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rs2_q       <= rs2_d;
      addr_q      <= addr_d;
      old_q       <= old_d;
      wdata_q     <= wdata_d;
      result_q    <= result_d;
      exc_q       <= exc_d;
      cause_q     <= cause_d;
      rsv_valid_q <= rsv_valid_d;
      rsv_addr_q  <= rsv_addr_d;
    end
  end

  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);
  assign exc_valid     = done && exc_q;
  assign exc_cause     = cause_q;
  assign result        = result_q;
  assign mem.mem_req   = (state_q == StRead) || (state_q == StWrite);
  assign mem.mem_we    = (state_q == StWrite);
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_amo_sequencer.sv
// Scoreboard bench for amo_sequencer: directed ops push expected beats and
// responses; a negedge monitor pops and compares them as the DUT presents them.
module tb_amo_sequencer;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SWAP = 5'b00001;
  localparam logic [4:0] OP_LR   = 5'b00010;
  localparam logic [4:0] OP_SC   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_OR   = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01100;
  localparam logic [4:0] OP_MIN  = 5'b10000;
  localparam logic [4:0] OP_MAX  = 5'b10100;
  localparam logic [4:0] OP_MINU = 5'b11000;
  localparam logic [4:0] OP_MAXU = 5'b11100;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cyc;
  } beat_t;

  typedef struct {
    logic [31:0] result;
    logic        exc;
    logic [5:0]  cause;
    int          cyc;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  amo_op;
  logic [31:0] addr;
  logic [31:0] rs2_data;
  logic        busy;
  logic        snoop_valid;
  logic [31:0] snoop_addr;
  logic        rsv_clear;
  logic        done;
  logic [31:0] result;
  logic        exc_valid;
  logic [5:0]  exc_cause;

  amo_sequencer_if #(.XLEN(32)) mem ();

  amo_sequencer #(.XLEN(32), .RSV_GRAN(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .amo_op      (amo_op),
    .addr        (addr),
    .rs2_data    (rs2_data),
    .busy        (busy),
    .mem         (mem),
    .snoop_valid (snoop_valid),
    .snoop_addr  (snoop_addr),
    .rsv_clear   (rsv_clear),
    .done        (done),
    .result      (result),
    .exc_valid   (exc_valid),
    .exc_cause   (exc_cause)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int cyc      = 0;

  beat_t beat_q[$];
  rsp_t  rsp_q[$];

  // Memory responder knobs.
  logic [31:0] rd_value;
  logic        err_r;
  logic        err_w;
  int          wait_cycles;
  int          wait_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Responder: decides ack a little after each rising edge.
  initial begin
    mem.mem_ack   = 1'b0;
    mem.mem_rdata = '0;
    mem.mem_err   = 1'b0;
    wait_cnt      = 0;
    forever begin
      @(posedge clk);
      #2;
      if (mem.mem_ack) wait_cnt = 0;
      if (!mem.mem_req) begin
        mem.mem_ack = 1'b0;
        mem.mem_err = 1'b0;
        wait_cnt    = 0;
      end else if (wait_cnt >= wait_cycles) begin
        mem.mem_ack   = 1'b1;
        mem.mem_rdata = rd_value;
        mem.mem_err   = mem.mem_we ? err_w : err_r;
      end else begin
        mem.mem_ack = 1'b0;
        mem.mem_err = 1'b0;
        wait_cnt++;
      end
    end
  end

  // Monitor.
  logic        pend = 1'b0;
  logic [31:0] p_addr;
  logic        p_we;

  always @(negedge clk) begin
    beat_t b;
    rsp_t  r;
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (mem.mem_req) begin
        if (pend) begin
          chk("stall_addr_stable", mem.mem_addr, p_addr);
          chk("stall_we_stable", {31'd0, mem.mem_we}, {31'd0, p_we});
        end
        if (mem.mem_ack) begin
          if (beat_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got we=%0b addr=0x%08h expected no beat",
                     mem.mem_we, mem.mem_addr);
          end else begin
            b = beat_q.pop_front();
            chk("beat_we", {31'd0, mem.mem_we}, {31'd0, b.we});
            chk("beat_addr", mem.mem_addr, b.addr);
            if (b.we) chk("beat_wdata", mem.mem_wdata, b.wdata);
            if (b.cyc >= 0) chk("beat_cycle", 32'(cyc), 32'(b.cyc));
          end
          pend = 1'b0;
        end else begin
          pend   = 1'b1;
          p_addr = mem.mem_addr;
          p_we   = mem.mem_we;
        end
      end else begin
        pend = 1'b0;
      end
      if (done) begin
        n_done++;
        if (rsp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done with result 0x%08h expected none", result);
        end else begin
          r = rsp_q.pop_front();
          chk("exc_valid", {31'd0, exc_valid}, {31'd0, r.exc});
          if (r.exc) chk("exc_cause", {26'd0, exc_cause}, {26'd0, r.cause});
          else       chk("result", result, r.result);
          if (r.cyc >= 0) chk("done_cycle", 32'(cyc), 32'(r.cyc));
        end
      end
    end
  end

  task automatic exp_beat(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input int off);
    beat_t b;
    b.we    = we;
    b.addr  = a;
    b.wdata = wd;
    b.cyc   = (off >= 0) ? cyc + off : -1;
    beat_q.push_back(b);
  endtask

  task automatic pulse_start(input logic [4:0] op, input logic [31:0] a, input logic [31:0] d);
    amo_op   = op;
    addr     = a;
    rs2_data = d;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int i;
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (n_done > d0) break;
    end
    if (n_done <= d0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done in 40 cycles expected done");
    end
    @(posedge clk);
    #1;
  endtask

  // Push the expected response, issue the op and wait for its completion.
  task automatic run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] d,
                     input int lat, input logic [31:0] res, input logic exc,
                     input logic [5:0] cause);
    rsp_t r;
    int   d0;
    r.result = res;
    r.exc    = exc;
    r.cause  = cause;
    r.cyc    = (lat > 0) ? cyc + lat : -1;
    rsp_q.push_back(r);
    d0 = n_done;
    pulse_start(op, a, d);
    wait_done(d0);
  endtask

  task automatic amo(input logic [4:0] op, input logic [31:0] a, input logic [31:0] old,
                     input logic [31:0] d, input logic [31:0] wd);
    rd_value = old;
    exp_beat(1'b0, a, '0, 1);
    exp_beat(1'b1, a, wd, 2);
    run(op, a, d, 3, old, 1'b0, 6'd0);
  endtask

  task automatic snoop(input logic [31:0] a);
    snoop_valid = 1'b1;
    snoop_addr  = a;
    @(posedge clk);
    #1;
    snoop_valid = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    amo_op      = '0;
    addr        = '0;
    rs2_data    = '0;
    snoop_valid = 1'b0;
    snoop_addr  = '0;
    rsv_clear   = 1'b0;
    rd_value    = '0;
    err_r       = 1'b0;
    err_w       = 1'b0;
    wait_cycles = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_req", {31'd0, mem.mem_req}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_mem_addr", mem.mem_addr, 32'd0);
    @(posedge clk);
    #1;

    // AMO datapath.
    amo(OP_ADD,  32'h100, 32'h10,       32'd5,        32'h15);
    amo(OP_MIN,  32'h104, 32'h1,        32'hFFFFFFFF, 32'hFFFFFFFF);
    amo(OP_MINU, 32'h104, 32'h1,        32'hFFFFFFFF, 32'h1);
    amo(OP_MAXU, 32'h104, 32'h1,        32'hFFFFFFFF, 32'hFFFFFFFF);
    amo(OP_MAX,  32'h104, 32'h1,        32'hFFFFFFFF, 32'h1);
    amo(OP_XOR,  32'h108, 32'hF0F0,     32'hFF,       32'hF00F);
    amo(OP_AND,  32'h108, 32'hF0F0,     32'hFF,       32'hF0);
    amo(OP_OR,   32'h108, 32'hF0F0,     32'hFF,       32'hF0FF);
    amo(OP_SWAP, 32'h10C, 32'h1234,     32'hABCD,     32'hABCD);
    amo(OP_ADD,  32'h10C, 32'hFFFFFFFF, 32'd2,        32'h1);

    // LR/SC pairing.
    rd_value = 32'h55;
    exp_beat(1'b0, 32'h200, '0, 1);
    run(OP_LR, 32'h200, 32'd0, 2, 32'h55, 1'b0, 6'd0);
    exp_beat(1'b1, 32'h200, 32'd7, 1);
    run(OP_SC, 32'h200, 32'd7, 2, 32'd0, 1'b0, 6'd0);
    run(OP_SC, 32'h200, 32'd7, 1, 32'd1, 1'b0, 6'd0);

    // Snoop in the same granule kills the reservation; next granule does not.
    exp_beat(1'b0, 32'h200, '0, 1);
    run(OP_LR, 32'h200, 32'd0, 2, 32'h55, 1'b0, 6'd0);
    snoop(32'h200);
    run(OP_SC, 32'h200, 32'd8, 1, 32'd1, 1'b0, 6'd0);
    exp_beat(1'b0, 32'h200, '0, 1);
    run(OP_LR, 32'h200, 32'd0, 2, 32'h55, 1'b0, 6'd0);
    snoop(32'h204);
    exp_beat(1'b1, 32'h200, 32'd9, 1);
    run(OP_SC, 32'h200, 32'd9, 2, 32'd0, 1'b0, 6'd0);

    // rsv_clear kills the reservation.
    exp_beat(1'b0, 32'h200, '0, 1);
    run(OP_LR, 32'h200, 32'd0, 2, 32'h55, 1'b0, 6'd0);
    rsv_clear = 1'b1;
    @(posedge clk);
    #1;
    rsv_clear = 1'b0;
    run(OP_SC, 32'h200, 32'd3, 1, 32'd1, 1'b0, 6'd0);

    // Exceptions.
    run(OP_SWAP, 32'h102, 32'd1, 1, 32'd0, 1'b1, 6'd6);
    run(OP_LR, 32'h201, 32'd0, 1, 32'd0, 1'b1, 6'd4);
    run(5'b00101, 32'h100, 32'd0, 1, 32'd0, 1'b1, 6'd2);
    err_r = 1'b1;
    exp_beat(1'b0, 32'h210, '0, 1);
    run(OP_LR, 32'h210, 32'd0, 2, 32'd0, 1'b1, 6'd5);
    exp_beat(1'b0, 32'h214, '0, 1);
    run(OP_ADD, 32'h214, 32'd1, 2, 32'd0, 1'b1, 6'd7);
    err_r = 1'b0;
    err_w = 1'b1;
    rd_value = 32'hF0;
    exp_beat(1'b0, 32'h110, '0, 1);
    exp_beat(1'b1, 32'h110, 32'hFF, 2);
    run(OP_OR, 32'h110, 32'h0F, 3, 32'd0, 1'b1, 6'd7);
    err_w = 1'b0;

    // Wait states on both beats.
    wait_cycles = 3;
    rd_value    = 32'h10;
    exp_beat(1'b0, 32'h120, '0, -1);
    exp_beat(1'b1, 32'h120, 32'h30, -1);
    run(OP_ADD, 32'h120, 32'h20, 9, 32'h10, 1'b0, 6'd0);

    // Reset during WRITE drops the beat and the reservation.
    wait_cycles = 0;
    rd_value    = 32'h77;
    exp_beat(1'b0, 32'h300, '0, 1);
    run(OP_LR, 32'h300, 32'd0, 2, 32'h77, 1'b0, 6'd0);
    wait_cycles = 3;
    rd_value    = 32'h0F;
    exp_beat(1'b0, 32'h300, '0, -1);
    pulse_start(OP_OR, 32'h300, 32'hF0);
    for (int i = 0; i < 20 && !mem.mem_we; i++) begin
      @(posedge clk);
      #1;
    end
    chk("reach_write", {31'd0, mem.mem_we}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_busy", {31'd0, busy}, 32'd0);
    chk("rstw_mem_req", {31'd0, mem.mem_req}, 32'd0);
    chk("rstw_mem_we", {31'd0, mem.mem_we}, 32'd0);
    chk("rstw_done", {31'd0, done}, 32'd0);
    chk("rstw_exc_valid", {31'd0, exc_valid}, 32'd0);
    chk("rstw_mem_addr", mem.mem_addr, 32'd0);
    chk("rstw_mem_wdata", mem.mem_wdata, 32'd0);
    chk("rstw_result", result, 32'd0);
    chk("rstw_exc_cause", {26'd0, exc_cause}, 32'd0);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    wait_cycles = 0;
    @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    run(OP_SC, 32'h300, 32'd9, 1, 32'd1, 1'b0, 6'd0);

    repeat (3) @(posedge clk);
    chk("beat_queue_empty", 32'(beat_q.size()), 32'd0);
    chk("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
